// File: rtl/ps2_tx_engine.sv
// rtl/ps2_tx_engine.sv - device-side PS/2 transmitter with byte FIFO, abort/retry, flush and inter-byte gap
module ps2_tx_engine #(
   parameter int FIFO_BITS = 3,
   parameter int PS2DIV    = 20,
   parameter int GAP       = 2
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [7:0]           wr_data,
   input  logic                 flush,
   input  logic                 inhibit,
   output logic                 ps2_clk,
   output logic                 ps2_data,
   output logic                 busy,
   output logic                 empty,
   output logic                 full,
   output logic [FIFO_BITS:0]   level,
   output logic                 overflow
);

   localparam int DIV_W = (PS2DIV > 2) ? $clog2(PS2DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PS2DIV - 1);
   localparam logic [FIFO_BITS:0] FULL_LVL = {1'b1, {FIFO_BITS{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_GAP} state_t;

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 phase_q, phase_d;
   logic [3:0]           idx_q, idx_d;
   logic [3:0]           gap_q, gap_d;
   logic [FIFO_BITS:0]   wptr_q, wptr_d;
   logic [FIFO_BITS:0]   rptr_q, rptr_d;
   logic                 ovf_q, ovf_d;
   logic                 clk_q, clk_d;
   logic                 data_q, data_d;
   logic [7:0]           mem_q [1 << FIFO_BITS];

   logic [7:0]           head;
   logic [FIFO_BITS:0]   lvl;
   logic                 rise;
   logic                 push;
   logic                 frame_bit;

   assign lvl      = wptr_q - rptr_q;
   assign head     = mem_q[rptr_q[FIFO_BITS-1:0]];
   assign rise     = (div_q == DIV_LAST) && !phase_q;
   assign push     = wr && (lvl != FULL_LVL) && !flush;

   assign level    = lvl;
   assign empty    = (lvl == '0);
   assign full     = (lvl == FULL_LVL);
   assign overflow = ovf_q;
   assign busy     = (state_q != S_IDLE);
   assign ps2_clk  = clk_q;
   assign ps2_data = data_q;

   // Bit that becomes valid on the next rise tick: data LSB first, odd parity, stop.
   always_comb begin
      frame_bit = 1'b1;
      if (idx_q < 4'd8) begin
         frame_bit = head[idx_q[2:0]];
      end else if (idx_q == 4'd8) begin
         frame_bit = ~^head;
      end
   end

   always_comb begin
      div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      phase_d = (div_q == DIV_LAST) ? ~phase_q : phase_q;
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      ovf_d   = ovf_q;
      clk_d   = 1'b1;
      data_d  = 1'b1;

      if (wr) begin
         if (lvl == FULL_LVL) begin
            ovf_d = 1'b1;
         end else begin
            wptr_d = wptr_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (rise && (lvl != '0) && !inhibit) begin
               state_d = S_SEND;
               idx_d   = 4'd0;
               data_d  = 1'b0;
            end
         end
         S_SEND: begin
            if (inhibit) begin
               state_d = S_HOLD;
            end else begin
               clk_d  = phase_d;
               data_d = data_q;
               if (rise) begin
                  if (idx_q == 4'd10) begin
                     rptr_d = rptr_q + 1'b1;
                     data_d = 1'b1;
                     if (GAP == 0) begin
                        state_d = S_IDLE;
                     end else begin
                        state_d = S_GAP;
                        gap_d   = 4'(GAP);
                     end
                  end else begin
                     idx_d  = idx_q + 4'd1;
                     data_d = frame_bit;
                  end
               end
            end
         end
         S_HOLD: begin
            // Head byte was never popped, so the retry resends it from the start bit.
            if (rise && !inhibit) begin
               state_d = S_SEND;
               idx_d   = 4'd0;
               data_d  = 1'b0;
            end
         end
         S_GAP: begin
            if (rise) begin
               gap_d = gap_q - 4'd1;
               if (gap_q <= 4'd1) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         ovf_d   = 1'b0;
         state_d = S_IDLE;
         idx_d   = 4'd0;
         gap_d   = 4'd0;
         clk_d   = 1'b1;
         data_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         phase_q <= 1'b0;
         idx_q   <= 4'd0;
         gap_q   <= 4'd0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ovf_q   <= 1'b0;
         clk_q   <= 1'b1;
         data_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
         clk_q   <= clk_d;
         data_q  <= data_d;
         if (push) begin
            mem_q[wptr_q[FIFO_BITS-1:0]] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_ps2_tx_engine.sv
// tb/tb_ps2_tx_engine.sv - directed scoreboard bench for ps2_tx_engine
module tb_ps2_tx_engine;

   localparam int FB  = 2;
   localparam int DIV = 4;
   localparam int GP  = 2;
   localparam int PERIOD = 2 * DIV;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          wr = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          flush = 1'b0;
   logic          inhibit = 1'b0;
   logic          ps2_clk;
   logic          ps2_data;
   logic          busy;
   logic          empty;
   logic          full;
   logic [FB:0]   level;
   logic          overflow;

   typedef struct {
      logic [7:0] b;
      logic       par;
   } sb_t;

   sb_t  sb[$];
   int   n_asserts = 0;
   int   n_fail = 0;
   int   nbits = 0;
   int   frames = 0;
   int   cyc = 0;

   ps2_tx_engine #(.FIFO_BITS(FB), .PS2DIV(DIV), .GAP(GP)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .wr       (wr),
      .wr_data  (wr_data),
      .flush    (flush),
      .inhibit  (inhibit),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .busy     (busy),
      .empty    (empty),
      .full     (full),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] b, input bit track);
      sb_t e;
      wr = 1'b1;
      wr_data = b;
      if (track) begin
         e.b = b;
         e.par = (($countones(b) % 2) == 0);
         sb.push_back(e);
      end
      @(negedge clk_sys);
      wr = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_ps2_clk", ps2_clk, 1);
      check("rst_ps2_data", ps2_data, 1);
      check("rst_busy", busy, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
   endtask

   // Host-side receiver: samples data on each ps2_clk falling edge.
   initial begin
      logic [10:0] fr;
      logic        prev_clk;
      sb_t         e;
      fr = '0;
      prev_clk = 1'b1;
      forever begin
         @(negedge clk_sys);
         #1;
         if (reset || flush || inhibit) begin
            nbits = 0;
         end else if (prev_clk && !ps2_clk) begin
            fr[nbits] = ps2_data;
            nbits++;
            if (nbits == 11) begin
               nbits = 0;
               frames++;
               check("frame_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("frame", 32'(fr), 32'({1'b1, e.par, e.b, 1'b0}));
                  check("parity", 32'(fr[9]), 32'(e.par));
               end
            end
         end
         prev_clk = ps2_clk;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t0;
      int t1;
      int f0;

      repeat (5) @(negedge clk_sys);
      check_reset_values();
      reset = 1'b0;
      @(negedge clk_sys);

      // Single byte: timing from start tick to pop.
      drive(8'hA5, 1);
      check("a5_level", level, 1);
      check("a5_empty", empty, 0);
      for (int i = 0; i < 40 && ps2_data !== 1'b0; i++) @(negedge clk_sys);
      check("a5_start", ps2_data, 0);
      t0 = cyc;
      for (int i = 0; i < 200 && level !== 3'd0; i++) @(negedge clk_sys);
      t1 = cyc;
      check("a5_pop_latency", t1 - t0, 22 * DIV);
      check("a5_empty_after", empty, 1);
      for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk_sys);
      check("a5_idle", busy, 0);

      // Parity cases and inter-frame gap: GAP periods plus the idle-to-start tick.
      drive(8'h00, 1);
      drive(8'hFF, 1);
      drive(8'h01, 1);
      check("par_level", level, 3);
      for (int i = 0; i < 200 && level !== 3'd2; i++) @(negedge clk_sys);
      t0 = cyc;
      for (int i = 0; i < 100 && ps2_data !== 1'b0; i++) @(negedge clk_sys);
      t1 = cyc;
      check("gap_cycles", t1 - t0, (GP + 1) * PERIOD);
      for (int i = 0; i < 600 && empty !== 1'b1; i++) @(negedge clk_sys);
      for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk_sys);
      check("par_sb_drained", sb.size(), 0);
      check("par_idle", busy, 0);

      // Fill under inhibit and overflow on the fifth byte.
      inhibit = 1'b1;
      for (int k = 0; k < 5; k++) drive(8'h10 + 8'(k), k < 4);
      repeat (20) @(negedge clk_sys);
      check("ovf_level", level, 4);
      check("ovf_full", full, 1);
      check("ovf_flag", overflow, 1);
      check("ovf_no_start", busy, 0);
      check("ovf_data_high", ps2_data, 1);
      inhibit = 1'b0;
      for (int i = 0; i < 1000 && empty !== 1'b1; i++) @(negedge clk_sys);
      for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk_sys);
      check("ovf_sb_drained", sb.size(), 0);
      check("ovf_sticky", overflow, 1);

      // Inhibit in the middle of a frame, then retry.
      f0 = frames;
      drive(8'h3C, 1);
      for (int i = 0; i < 200 && nbits != 5; i++) @(negedge clk_sys);
      check("inh_at_idx4", nbits, 5);
      check("inh_clk_low", ps2_clk, 0);
      inhibit = 1'b1;
      @(negedge clk_sys);
      check("inh_clk_high", ps2_clk, 1);
      check("inh_data_high", ps2_data, 1);
      check("inh_level", level, 1);
      repeat (40) @(negedge clk_sys);
      check("inh_hold_busy", busy, 1);
      check("inh_hold_clk", ps2_clk, 1);
      check("inh_hold_level", level, 1);
      inhibit = 1'b0;
      for (int i = 0; i < 300 && empty !== 1'b1; i++) @(negedge clk_sys);
      for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk_sys);
      check("inh_frames", frames - f0, 1);
      check("inh_sb_drained", sb.size(), 0);

      // Flush mid-frame with a colliding write.
      drive(8'h77, 0);
      for (int i = 0; i < 200 && nbits != 3; i++) @(negedge clk_sys);
      f0 = frames;
      flush = 1'b1;
      wr = 1'b1;
      wr_data = 8'h55;
      @(negedge clk_sys);
      flush = 1'b0;
      wr = 1'b0;
      check("fl_level", level, 0);
      check("fl_overflow", overflow, 0);
      check("fl_clk", ps2_clk, 1);
      check("fl_data", ps2_data, 1);
      check("fl_busy", busy, 0);
      repeat (250) @(negedge clk_sys);
      check("fl_no_frames", frames - f0, 0);
      check("fl_level_later", level, 0);
      check("fl_data_later", ps2_data, 1);

      // Reset at bit index 7, then a clean transfer.
      drive(8'h99, 0);
      for (int i = 0; i < 200 && nbits != 8; i++) @(negedge clk_sys);
      check("rs_at_idx7", nbits, 8);
      reset = 1'b1;
      @(negedge clk_sys);
      check_reset_values();
      reset = 1'b0;
      @(negedge clk_sys);
      f0 = frames;
      drive(8'h12, 1);
      for (int i = 0; i < 300 && empty !== 1'b1; i++) @(negedge clk_sys);
      for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk_sys);
      check("rs_frames", frames - f0, 1);
      check("rs_sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
